// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-file address constants and the load-use hazard predicate.
package pipeline_pkg;

    // Register-file address width and the hard-wired zero register
    localparam int         REG_AW   = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Sequencer state encoding
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        S_RUN    = ST_RUN,
        S_DRAIN  = ST_DRAIN,
        S_HALTED = ST_HALTED
    } hz_state_e;

    // A load in EX whose destination is a source of the instruction in ID.
    // Writes to the zero register never create a dependency.
    function automatic logic load_use_hazard(
        input logic              ex_mem_read,
        input logic [REG_AW-1:0] ex_rt,
        input logic [REG_AW-1:0] id_rs,
        input logic [REG_AW-1:0] id_rt,
        input logic              id_uses_rt
    );
        logic dep_rs;
        logic dep_rt;
        dep_rs = (ex_rt == id_rs);
        dep_rt = id_uses_rt && (ex_rt == id_rt);
        return ex_mem_read && (ex_rt != REG_ZERO) && (dep_rs || dep_rt);
    endfunction

endpackage : pipeline_pkg

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = &r_count;

    // Count qualified events, sticking at the maximum value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Handles load-use stalls, taken-branch squashes resolved in MEM and the
// HALT drain/freeze sequence. Control outputs are combinational so they act
// in the cycle the condition is seen; halted is registered.
// Optional macro HAZARD_PERF_CNT_EN: when defined, stall/flush performance
// counters are built; otherwise both counter ports are tied to zero.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_mem_pc_src,
    input  logic              i_id_halt,
    input  logic              i_resume,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_if_id_flush,
    output logic              o_id_ex_flush,
    output logic              o_ex_mem_flush,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    hz_state_e   r_state;
    logic [DW-1:0] r_drain_cnt;
    logic        r_halted;

    logic        w_luh;
    logic        w_branch;

    assign w_luh    = load_use_hazard(i_ex_mem_read, i_ex_rt, i_id_rs,
                                      i_id_rt, i_id_uses_rt);
    assign w_branch = i_mem_pc_src;

    // Pipeline enables and flushes from the current state and hazards
    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_branch) begin
                    // Squash the three younger wrong-path instructions
                    o_if_id_flush  = 1'b1;
                    o_id_ex_flush  = 1'b1;
                    o_ex_mem_flush = 1'b1;
                end else if (w_luh) begin
                    // Hold PC and IF/ID, insert one bubble into EX
                    o_pc_write    = 1'b0;
                    o_if_id_write = 1'b0;
                    o_id_ex_flush = 1'b1;
                end else if (i_id_halt) begin
                    // HALT leaves ID as a bubble; nothing younger is fetched
                    o_pc_write    = 1'b0;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_branch) begin
                    // Older branch taken: the HALT was wrong-path, redirect
                    o_if_id_flush  = 1'b1;
                    o_id_ex_flush  = 1'b1;
                    o_ex_mem_flush = 1'b1;
                end else begin
                    o_pc_write    = 1'b0;
                    o_if_id_write = 1'b0;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end
            end
            S_HALTED: begin
                o_pc_write     = 1'b0;
                o_if_id_write  = 1'b0;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
            end
            default: begin
                o_pc_write     = 1'b1;
                o_if_id_write  = 1'b1;
            end
        endcase
    end

    // Sequencer state, drain timer and registered halted flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            // halted follows the HALTED state one cycle later, and drops
            // together with the state when resume is taken
            r_halted <= (r_state == S_HALTED) && !i_resume;
            case (r_state)
                S_RUN: begin
                    if (!w_branch && !w_luh && i_id_halt) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_branch) begin
                        r_state     <= S_RUN;
                        r_drain_cnt <= '0;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state     <= S_HALTED;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_HALTED: begin
                    if (i_resume) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state     <= S_RUN;
                    r_drain_cnt <= '0;
                end
            endcase
        end
    end

    assign o_halted = r_halted;

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;

    // A stall cycle is a load-use hold in RUN not overridden by a branch
    assign w_stall_inc = (r_state == S_RUN) && w_luh && !w_branch;
    // A flush event is any taken branch seen while instructions still flow
    assign w_flush_inc = (r_state != S_HALTED) && w_branch;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_flush_inc),
        .o_count (o_flush_cnt)
    );
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with a few
// literal expectations followed by randomized traffic, all compared every
// cycle against a behavioural model of the stall/flush/halt rules.
module tb_pipeline_hazard_ctrl;

    localparam int DC = 3;
    localparam int CW = 4;   // narrow counters so saturation is reachable
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read, mem_pc_src, id_halt, resume;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic          halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (DC),
        .CNT_W        (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rt   (id_uses_rt),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_rt        (ex_rt),
        .i_mem_pc_src   (mem_pc_src),
        .i_id_halt      (id_halt),
        .i_resume       (resume),
        .o_pc_write     (pc_write),
        .o_if_id_write  (if_id_write),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_flush (ex_mem_flush),
        .o_halted       (halted),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    // Behavioural model: pipeline is flowing, draining (with cycles done),
    // or frozen; plus the visible halted flag and event tallies.
    bit m_draining;
    bit m_frozen;
    int m_drain_done;
    bit m_halted_vis;
    int m_stalls;
    int m_flushes;

    task automatic model_reset();
        m_draining   = 0;
        m_frozen     = 0;
        m_drain_done = 0;
        m_halted_vis = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (txn %0d)", name, act, exp, txn);
        end
    endtask

    function automatic bit model_luh();
        bit same_rs, same_rt;
        same_rs = (int'(ex_rt) == int'(id_rs));
        same_rt = id_uses_rt && (int'(ex_rt) == int'(id_rt));
        return ex_mem_read && (ex_rt != 0) && (same_rs || same_rt);
    endfunction

    // Check every output against the model for the inputs currently applied
    task automatic check_outputs();
        bit luh, br;
        int e_pc, e_ifw, e_iff, e_idf, e_emf;
        luh = model_luh();
        br  = mem_pc_src;
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_emf = 0;
        if (m_frozen) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_emf = 1;
        end else if (br) begin
            e_iff = 1; e_idf = 1; e_emf = 1;
        end else if (m_draining) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (luh) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
        end else if (id_halt) begin
            e_pc = 0; e_iff = 1; e_idf = 1;
        end
        chk("pc_write",     int'(pc_write),     e_pc);
        chk("if_id_write",  int'(if_id_write),  e_ifw);
        chk("if_id_flush",  int'(if_id_flush),  e_iff);
        chk("id_ex_flush",  int'(id_ex_flush),  e_idf);
        chk("ex_mem_flush", int'(ex_mem_flush), e_emf);
        chk("halted",       int'(halted),       int'(m_halted_vis));
        chk("stall_cnt",    int'(stall_cnt),    PERF ? m_stalls  : 0);
        chk("flush_cnt",    int'(flush_cnt),    PERF ? m_flushes : 0);
    endtask

    // Advance the model across one rising edge with the applied inputs
    task automatic model_advance();
        bit luh, br, flowing;
        luh = model_luh();
        br  = mem_pc_src;
        flowing = !m_draining && !m_frozen;
        if (flowing && luh && !br && m_stalls < CMAX) m_stalls++;
        if (!m_frozen && br && m_flushes < CMAX)      m_flushes++;
        m_halted_vis = m_frozen && !resume;
        if (m_frozen) begin
            if (resume) m_frozen = 0;
        end else if (m_draining) begin
            if (br) begin
                m_draining = 0;
            end else begin
                m_drain_done++;
                if (m_drain_done == DC) begin
                    m_draining = 0;
                    m_frozen   = 1;
                end
            end
        end else if (!br && !luh && id_halt) begin
            m_draining   = 1;
            m_drain_done = 0;
        end
    endtask

    // One transaction: called just after a falling edge, returns after the next
    task automatic step(input bit [4:0] rs, input bit [4:0] rt, input bit ut,
                        input bit mr, input bit [4:0] ert, input bit br,
                        input bit hlt, input bit res);
        id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_mem_read = mr;
        ex_rt = ert; mem_pc_src = br; id_halt = hlt; resume = res;
        #1;
        check_outputs();
        $display("txn %0d rs=%0d rt=%0d ut=%0b mr=%0b ert=%0d br=%0b hlt=%0b res=%0b -> pcw=%0b ifw=%0b flush=%0b%0b%0b halted=%0b sc=%0d fc=%0d",
                 txn, rs, rt, ut, mr, ert, br, hlt, res, pc_write, if_id_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, halted, stall_cnt, flush_cnt);
        @(posedge clk);
        model_advance();
        @(negedge clk);
        txn++;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_mem_read = 0;
        ex_rt = '0; mem_pc_src = 0; id_halt = 0; resume = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        chk("reset_halted_lit", int'(halted), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load-use on rs, then ex_rt=0 never stalls
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle();
        chk("luh_stall_cnt_lit", int'(stall_cnt), PERF ? 1 : 0);
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        // rt dependency only when rt is a source
        step(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        // Branch and load-use together: branch wins
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        idle();
        chk("br_flush_cnt_lit", int'(flush_cnt), PERF ? 1 : 0);
        chk("br_stall_cnt_lit", int'(stall_cnt), PERF ? 2 : 0);

        // Halt: 3 drain cycles, HALTED, halted visible on the 5th cycle
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle();
        chk("halt_vis_lit", int'(halted), 1);
        chk("halt_pcw_lit", int'(pc_write), 0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("resume_halted_lit", int'(halted), 0);
        chk("resume_pcw_lit", int'(pc_write), 1);
        idle();

        // Abort drain with a branch on the 2nd drain cycle
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("abort_pcw_lit", int'(pc_write), 1);
        for (int i = 0; i < 4; i++) idle();

        // Asynchronous reset in the middle of a drain
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rst_halted", int'(halted), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 2500; n++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX.
- Squashes wrong-path work when a branch resolves taken in MEM.
- Sequences a halt: drain older instructions, then freeze PC.
- Drives the PC write enable, the IF/ID write enable and the per-latch bubble/flush controls.

Parameters:
- DRAIN_CYCLES, 3: cycles spent in DRAIN before HALTED (covers EX, MEM, WB of older instructions).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- ex_mem_read  in  1  MemRead control of the instruction in EX.
- ex_rt  in  5  destination rt of the load in EX.
- mem_pc_src  in  1  branch taken, resolved in MEM (Branch AND zero).
- id_halt  in  1  instruction in ID is HALT.
- resume  in  1  leave HALTED; level, sampled on the clock edge.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID latch enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_flush  out  1  ID/EX control fields cleared (bubble).
- ex_mem_flush  out  1  EX/MEM control fields cleared.
- halted  out  1  registered; 1 in HALTED state.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- States: RUN, DRAIN, HALTED. A 2-bit state register and a drain counter are the only state besides the perf counters.
- Reset (reset=0, asynchronous): state=RUN, drain counter=0, halted=0, counters=0.
- Control outputs are combinational from state and inputs, so they act in the same cycle.
- Default outputs in RUN: pc_write=1, if_id_write=1, all flushes=0.

Load-use hazard:
- luh = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN & luh & !mem_pc_src: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble per load.

Taken branch (RUN):
- mem_pc_src=1: pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
- Branch has priority over luh and id_halt.

Halt:
- RUN & id_halt & !luh & !mem_pc_src: id_ex_flush=1, if_id_flush=1, pc_write=0. Next state DRAIN, drain counter=0.
- id_halt together with luh: stall first; halt is taken once luh clears.
- DRAIN: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1. Counter increments each cycle; at DRAIN_CYCLES-1 the next state is HALTED.
- DRAIN & mem_pc_src=1 (older branch taken, so HALT was wrong-path): apply the branch flush outputs with pc_write=1, and return to RUN next cycle. Drain is aborted.
- HALTED: pc_write=0, if_id_write=0, all flushes=1. halted=1 is registered, visible the cycle after entry.
- resume=1 in HALTED: next state RUN, halted=0, and the PC fetches from its held value.
- resume is ignored in RUN and DRAIN.

Counters:
- Saturate at all-ones; no wrap.
- stall_cnt increments per luh stall cycle.
- flush_cnt increments per RUN/DRAIN cycle with mem_pc_src=1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt are implemented as above.
- Undefined: no counter flops; both ports are tied to 0.
- FSM and control behaviour are identical either way.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding localparams ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2;
  - REG_ZERO=5'd0;
  - register-address width REG_AW=5.
- One sub-module, sat_counter (parameter W, ports clk, reset, inc, count), instantiated twice under the macro.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cnt 0->1. Repeat with ex_rt=0 -> no stall.
- rt-only dependency: ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall; then id_uses_rt=1 -> stall.
- Branch vs load-use in the same cycle: mem_pc_src=1 and luh=1 -> pc_write=1, all three flushes=1, stall_cnt unchanged, flush_cnt +1.
- Halt: id_halt=1 in RUN -> DRAIN for exactly 3 cycles with pc_write=0; halted=1 on cycle 5 after halt seen; resume=1 -> halted=0 next cycle, pc_write=1.
- Abort drain: mem_pc_src=1 on 2nd DRAIN cycle -> flush outputs asserted, state RUN next cycle, halted never asserted.
- Reset mid-DRAIN: reset=0 asynchronously -> halted=0, counters=0, and after release pc_write=1 in RUN. With macro undefined, counters read 0 throughout.
